// File: rtl/necpu_pkg.sv
// Shared NECPU definitions: opcodes, instruction field layout, decoded-instruction
// record and front-end FSM states.
package necpu_pkg;

  localparam int unsigned PC_WIDTH   = 8;
  localparam int unsigned INST_WIDTH = 16;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RA_MSB  = 7;
  localparam int unsigned RA_LSB  = 4;
  localparam int unsigned RB_MSB  = 3;
  localparam int unsigned RB_LSB  = 0;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [3:0] {
    InstNOP   = 4'd0,
    InstLOAD  = 4'd1,
    InstSTORE = 4'd2,
    InstSET   = 4'd3,
    InstLT    = 4'd4,
    InstEQ    = 4'd5,
    InstBEQ   = 4'd6,
    InstBNEQ  = 4'd7,
    InstADD   = 4'd8,
    InstSUB   = 4'd9,
    InstSHL   = 4'd10,
    InstSHR   = 4'd11,
    InstAND   = 4'd12,
    InstOR    = 4'd13,
    InstINV   = 4'd14,
    InstXOR   = 4'd15
  } opcode_e;

  typedef struct packed {
    logic wr_reg;
    logic is_branch;
    logic wr_pc;
    logic is_mem;
  } dec_flags_t;

  typedef struct packed {
    opcode_e    opcode;
    logic [3:0] rd;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [7:0] imm8;
    dec_flags_t flags;
  } dec_inst_t;

  typedef enum logic [1:0] {
    StStop = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } fetch_state_e;

  // Every opcode that produces a register result, including the R0/PC alias.
  function automatic logic is_reg_write(input opcode_e op);
    return op inside {InstLOAD, InstSET, InstLT, InstEQ, InstADD, InstSUB,
                      InstSHL, InstSHR, InstAND, InstOR, InstINV, InstXOR};
  endfunction

endpackage

// File: rtl/inst_fetch_decode_if.sv
// Front-end bus: ROM address/data, redirect from execute and decode slot handshake.
interface inst_fetch_decode_if #(
  parameter int unsigned PC_W   = 8,
  parameter int unsigned INST_W = 16
);

  logic [PC_W-1:0]   rom_addr;
  logic [INST_W-1:0] rom_inst;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              dec_valid;
  logic              dec_ready;
  logic [PC_W-1:0]   dec_pc;
  logic [3:0]        dec_opcode;
  logic [3:0]        dec_rd;
  logic [3:0]        dec_ra;
  logic [3:0]        dec_rb;
  logic [7:0]        dec_imm8;
  logic              dec_wr_reg;
  logic              dec_is_branch;
  logic              dec_wr_pc;
  logic              dec_is_mem;

  modport master (
    output rom_addr,
    input  rom_inst,
    input  redirect_valid,
    input  redirect_pc,
    output dec_valid,
    input  dec_ready,
    output dec_pc,
    output dec_opcode,
    output dec_rd,
    output dec_ra,
    output dec_rb,
    output dec_imm8,
    output dec_wr_reg,
    output dec_is_branch,
    output dec_wr_pc,
    output dec_is_mem
  );

  modport slave (
    input  rom_addr,
    output rom_inst,
    output redirect_valid,
    output redirect_pc,
    input  dec_valid,
    output dec_ready,
    input  dec_pc,
    input  dec_opcode,
    input  dec_rd,
    input  dec_ra,
    input  dec_rb,
    input  dec_imm8,
    input  dec_wr_reg,
    input  dec_is_branch,
    input  dec_wr_pc,
    input  dec_is_mem
  );

endinterface

// File: rtl/inst_decode.sv
// Combinational instruction word to fields/class-flags decoder, shared by
// fetch, execute and debug views.
module inst_decode
  import necpu_pkg::*;
#(
  parameter int unsigned INST_W = INST_WIDTH
) (
  input  logic [INST_W-1:0] inst,
  output dec_inst_t         dec
);

  opcode_e    opcode;
  logic [3:0] rd;
  logic       wr_reg;

  always_comb begin
    opcode = opcode_e'(inst[OPC_MSB:OPC_LSB]);
    rd     = inst[RD_MSB:RD_LSB];
    wr_reg = is_reg_write(opcode);

    dec                 = '0;
    dec.opcode          = opcode;
    dec.rd              = rd;
    dec.ra              = inst[RA_MSB:RA_LSB];
    dec.rb              = inst[RB_MSB:RB_LSB];
    dec.imm8            = inst[IMM_MSB:IMM_LSB];
    dec.flags.wr_reg    = wr_reg;
    dec.flags.is_branch = opcode inside {InstBEQ, InstBNEQ};
    dec.flags.is_mem    = opcode inside {InstLOAD, InstSTORE};
    // R0 doubles as the PC, so a write to it is a jump execute must redirect.
    dec.flags.wr_pc     = wr_reg && (rd == '0);
  end

endmodule

// File: rtl/inst_fetch_decode.sv
// NECPU fetch/decode front end: owns the fetch PC, registers the ROM word with
// its decode into a single slot and hands it to execute over valid/ready.
module inst_fetch_decode
  import necpu_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_WIDTH,
  parameter int unsigned     INST_W   = INST_WIDTH,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  inst_fetch_decode_if.master bus
);

  fetch_state_e    state;
  fetch_state_e    state_next;
  logic [PC_W-1:0] pc;
  logic            slot_valid;
  logic [PC_W-1:0] slot_pc;
  dec_inst_t       slot;
  dec_inst_t       dec_word;
  logic            slot_free;
  logic            capture;

  inst_decode #(
    .INST_W (INST_W)
  ) u_decode (
    .inst (bus.rom_inst),
    .dec  (dec_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= StStop;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (bus.redirect_valid) begin
      state_next = run ? StRun : StStop;
    end else begin
      unique case (state)
        StStop: begin
          if (run) state_next = StRun;
        end
        StRun: begin
          if (slot_valid && !bus.dec_ready) state_next = StHold;
          else if (!run)                    state_next = StStop;
        end
        StHold: begin
          if (bus.dec_ready) state_next = run ? StRun : StStop;
        end
        default: state_next = StStop;
      endcase
    end
  end

  // HOLD also captures on the cycle its slot drains, so release costs no bubble.
  always_comb begin
    slot_free = !slot_valid || bus.dec_ready;
    capture   = run && slot_free && !bus.redirect_valid && (state != StStop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      slot_valid <= 1'b0;
      slot_pc    <= '0;
      slot       <= '0;
    end else if (bus.redirect_valid) begin
      pc         <= bus.redirect_pc;
      slot_valid <= 1'b0;
    end else if (capture) begin
      pc         <= pc + PC_W'(1);
      slot_valid <= 1'b1;
      slot_pc    <= pc;
      slot       <= dec_word;
    end else if (bus.dec_ready) begin
      slot_valid <= 1'b0;
    end
  end

  assign bus.rom_addr      = pc;
  assign bus.dec_valid     = slot_valid;
  assign bus.dec_pc        = slot_pc;
  assign bus.dec_opcode    = slot.opcode;
  assign bus.dec_rd        = slot.rd;
  assign bus.dec_ra        = slot.ra;
  assign bus.dec_rb        = slot.rb;
  assign bus.dec_imm8      = slot.imm8;
  assign bus.dec_wr_reg    = slot.flags.wr_reg;
  assign bus.dec_is_branch = slot.flags.is_branch;
  assign bus.dec_wr_pc     = slot.flags.wr_pc;
  assign bus.dec_is_mem    = slot.flags.is_mem;

endmodule
